duft_scan_ctrl: RTL and testbench

Control stage sitting directly upstream of the DUT datapath's scan register. It drives the register's functional and scan controls and consumes its serial scan output.
- In functional mode it passes host enable/select through to the datapath.
- On a dump request it freezes the datapath and rotates the full scan chain, with sout fed back to sin, so register state is restored after exactly CHAIN_LEN shifts.
- It presents the captured value in parallel to the host with an acknowledge pulse.

---
 rtl/duft_pkg.sv | 10 +
 rtl/duft_cap_sreg.sv | 25 ++
 rtl/duft_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_duft_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duft_pkg.sv
// Shared types and defaults for the scan-dump controller.
package duft_pkg;
  localparam int CHAIN_LEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/duft_cap_sreg.sv
// Serial-in / parallel-out shift register, LSB-ward shift with MSB entry.
// Used both as the scan capture register and as the load shifter.
module duft_cap_sreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/duft_scan_ctrl.sv
// Scan-dump controller in front of the datapath scan register.
// Optional scan-load path enabled by defining DUFT_SCAN_LOAD_EN.
//
// state    | meaning
// ST_IDLE  | functional pass-through, waiting for a request
// ST_SHIFT | CHAIN_LEN rotate cycles, capturing sout
// ST_DONE  | one cycle, dump_ack with the full capture
module duft_scan_ctrl
  import duft_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 func_en,
  input  logic                 func_sel,
  input  logic                 dump_req,
  output logic                 busy,
  output logic                 dump_ack,
  output logic [CHAIN_LEN-1:0] dump_data,
  output logic                 sen,
  output logic                 scan_ce,
  output logic                 reg_en,
  output logic                 reg_sel,
  output logic                 sin,
  input  logic                 sout
`ifdef DUFT_SCAN_LOAD_EN
  ,
  input  logic                 load_req,
  input  logic [CHAIN_LEN-1:0] load_data
`endif
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] dump_q;
  logic                 is_idle;
  logic                 start;
  logic                 last_shift;

  assign is_idle    = (state == ST_IDLE);
  assign last_shift = (state == ST_SHIFT) && (cnt == CNT_W'(CHAIN_LEN - 1));

`ifdef DUFT_SCAN_LOAD_EN
  logic                 loading;
  logic [CHAIN_LEN-1:0] ld_q;

  assign start = is_idle && (dump_req || load_req);
  assign sin   = sen & (loading ? ld_q[0] : sout);

  duft_cap_sreg #(.WIDTH(CHAIN_LEN)) u_load_sreg (
    .clk      (clk),
    .reset    (reset),
    .load     (is_idle && load_req),
    .load_val (load_data),
    .shift    (sen),
    .din      (1'b0),
    .q        (ld_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loading <= 1'b0;
    end else if (is_idle) begin
      loading <= load_req;
    end
  end
`else
  assign start = is_idle && dump_req;
  assign sin   = sen & sout;
`endif

  // Reset gates the pass-through so the datapath never sees an enable in reset.
  assign reg_en    = reset & is_idle & func_en;
  assign reg_sel   = reset & is_idle & func_sel;
  assign dump_data = (state == ST_DONE) ? cap_q : dump_q;

  duft_cap_sreg #(.WIDTH(CHAIN_LEN)) u_cap_sreg (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .shift    (sen),
    .din      (sout),
    .q        (cap_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dump_q   <= '0;
      dump_ack <= 1'b0;
      busy     <= 1'b0;
      sen      <= 1'b0;
      scan_ce  <= 1'b0;
    end else begin
      dump_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SHIFT;
            cnt     <= '0;
            busy    <= 1'b1;
            sen     <= 1'b1;
            scan_ce <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          if (last_shift) begin
            state    <= ST_DONE;
            sen      <= 1'b0;
            scan_ce  <= 1'b0;
            dump_ack <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          dump_q <= cap_q;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          sen     <= 1'b0;
          scan_ce <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duft_scan_ctrl.sv
// Bench for duft_scan_ctrl with a behavioural datapath scan register.
`timescale 1ns/1ps
module tb_duft_scan_ctrl;
  localparam int CL = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          func_en = 1'b0;
  logic          func_sel = 1'b0;
  logic          dump_req = 1'b0;
  logic          busy, dump_ack, sen, scan_ce, reg_en, reg_sel, sin, sout;
  logic [CL-1:0] dump_data;
  logic [CL-1:0] data_in = '0;
  logic [CL-1:0] dp = '0;
`ifdef DUFT_SCAN_LOAD_EN
  logic          load_req = 1'b0;
  logic [CL-1:0] load_data = '0;
`endif

  int            checks = 0;
  int            failures = 0;
  logic [CL-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Datapath: scan rotates right (sout = bit 0), functional path loads or increments.
  assign sout = dp[0];
  always @(posedge clk) begin
    if (scan_ce && sen) dp <= {sin, dp[CL-1:1]};
    else if (reg_en)    dp <= reg_sel ? data_in : dp + 1;
  end

  duft_scan_ctrl #(.CHAIN_LEN(CL), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .func_en   (func_en),
    .func_sel  (func_sel),
    .dump_req  (dump_req),
    .busy      (busy),
    .dump_ack  (dump_ack),
    .dump_data (dump_data),
    .sen       (sen),
    .scan_ce   (scan_ce),
    .reg_en    (reg_en),
    .reg_sel   (reg_sel),
    .sin       (sin),
    .sout      (sout)
`ifdef DUFT_SCAN_LOAD_EN
    ,
    .load_req  (load_req),
    .load_data (load_data)
`endif
  );

  // Waits through one request; returns shift-cycle count, ack cycle index and data.
  task automatic observe_dump(input bit hold, output int sen_cnt, output int ack_at,
                              output logic [CL-1:0] data);
    sen_cnt = 0;
    ack_at  = 0;
    data    = '0;
    @(posedge clk);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (!hold && i == 1) begin
        dump_req = 1'b0;
        func_en  = 1'b0;
`ifdef DUFT_SCAN_LOAD_EN
        load_req = 1'b0;
`endif
      end
      if (sen) sen_cnt++;
      if (dump_ack) begin
        ack_at = i;
        data   = dump_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    func_en  = 1'b1;
    func_sel = 1'b1;
    dump_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, dump_ack, sen, scan_ce, reg_en, reg_sel, sin} !== 7'b0 || dump_data !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got ctl=%b data=%0h expected ctl=0000000 data=0",
                 {busy, dump_ack, sen, scan_ce, reg_en, reg_sel, sin}, dump_data);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || reg_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got busy=%b reg_en=%b expected busy=0 reg_en=1", busy, reg_en);
    end
    func_en  = 1'b0;
    func_sel = 1'b0;
    dump_req = 1'b0;
  endtask

  task automatic test_func_passthrough();
    int sen_seen;
    sen_seen = 0;
    @(negedge clk);
    func_en  = 1'b1;
    func_sel = 1'b1;
    data_in  = 32'h0000_0005;
    @(negedge clk);
    checks++;
    if (dp !== 32'h0000_0005 || sin !== 1'b0) begin
      failures++;
      $display("FAIL func_load: got dp=%0h sin=%b expected dp=5 sin=0", dp, sin);
    end
    func_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (sen || scan_ce) sen_seen++;
      checks++;
      if (reg_en !== 1'b1 || reg_sel !== 1'b0) begin
        failures++;
        $display("FAIL func_passthru: got reg_en=%b reg_sel=%b expected reg_en=1 reg_sel=0", reg_en, reg_sel);
      end
      @(negedge clk);
    end
    func_en = 1'b0;
    checks++;
    if (dp !== 32'h0000_0008 || sen_seen != 0) begin
      failures++;
      $display("FAIL func_incr: got dp=%0h sen_cycles=%0d expected dp=8 sen_cycles=0", dp, sen_seen);
    end
  endtask

  task automatic test_dump();
    int            sc, aa;
    logic [CL-1:0] d, e;
    dump_req = 1'b1;
    exp_q.push_back(32'h0000_0008);
    observe_dump(1'b0, sc, aa, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (sc != 32 || aa != 33) begin
      failures++;
      $display("FAIL dump_timing: got sen_cycles=%0d ack_cycle=%0d expected 32 and 33", sc, aa);
    end
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL dump_data: got %0h expected %0h", d, e);
    end
    @(negedge clk);
    checks++;
    if (dump_ack !== 1'b0 || busy !== 1'b0 || dump_data !== 32'h0000_0008 || dp !== 32'h0000_0008) begin
      failures++;
      $display("FAIL dump_after: got ack=%b busy=%b data=%0h dp=%0h expected 0 0 8 8",
               dump_ack, busy, dump_data, dp);
    end
  endtask

  task automatic test_resume();
    func_en  = 1'b1;
    func_sel = 1'b0;
    @(negedge clk);
    func_en = 1'b0;
    checks++;
    if (dp !== 32'h0000_0009) begin
      failures++;
      $display("FAIL resume: got dp=%0h expected 9", dp);
    end
  endtask

  task automatic test_back_to_back();
    int            sc, aa;
    logic [CL-1:0] d, e;
    func_en  = 1'b1;
    func_sel = 1'b1;
    data_in  = 32'hA5A5_A5A5;
    @(negedge clk);
    dump_req = 1'b1;
    exp_q.push_back(32'hA5A5_A5A5);
    exp_q.push_back(32'hA5A5_A5A5);
    observe_dump(1'b1, sc, aa, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (sc != 32 || aa != 33 || d !== e) begin
      failures++;
      $display("FAIL busy_dump1: got sen=%0d ack=%0d data=%0h expected 32 33 %0h", sc, aa, d, e);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sen !== 1'b0) begin
      failures++;
      $display("FAIL busy_gap: got busy=%b sen=%b expected 0 0", busy, sen);
    end
    observe_dump(1'b0, sc, aa, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (sc != 32 || aa != 33 || d !== e) begin
      failures++;
      $display("FAIL busy_dump2: got sen=%0d ack=%0d data=%0h expected 32 33 %0h", sc, aa, d, e);
    end
    @(negedge clk);
    checks++;
    if (dp !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL busy_frozen: got dp=%0h expected a5a5a5a5", dp);
    end
  endtask

  task automatic test_reset_mid_dump();
    dump_req = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) dump_req = 1'b0;
    end
    checks++;
    if (sen !== 1'b1) begin
      failures++;
      $display("FAIL mid_shifting: got sen=%b expected 1", sen);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (sen !== 1'b0 || scan_ce !== 1'b0 || busy !== 1'b0 || dump_data !== '0) begin
      failures++;
      $display("FAIL mid_reset: got sen=%b ce=%b busy=%b data=%0h expected 0 0 0 0",
               sen, scan_ce, busy, dump_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (sen !== 1'b0 || busy !== 1'b0 || dump_ack !== 1'b0 || dump_data !== '0) begin
      failures++;
      $display("FAIL mid_idle: got sen=%b busy=%b ack=%b data=%0h expected 0 0 0 0",
               sen, busy, dump_ack, dump_data);
    end
  endtask

`ifdef DUFT_SCAN_LOAD_EN
  task automatic test_load();
    int            sc, aa;
    logic [CL-1:0] d, e;
    func_en  = 1'b1;
    func_sel = 1'b1;
    data_in  = 32'h1234_5678;
    @(negedge clk);
    func_en   = 1'b0;
    func_sel  = 1'b0;
    load_req  = 1'b1;
    dump_req  = 1'b1;
    load_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'h1234_5678);
    observe_dump(1'b0, sc, aa, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (sc != 32 || aa != 33 || d !== e) begin
      failures++;
      $display("FAIL load_dump: got sen=%0d ack=%0d data=%0h expected 32 33 %0h", sc, aa, d, e);
    end
    @(negedge clk);
    checks++;
    if (dp !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_value: got dp=%0h expected deadbeef", dp);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_func_passthrough();
    test_dump();
    test_resume();
    test_back_to_back();
    test_reset_mid_dump();
`ifdef DUFT_SCAN_LOAD_EN
    test_load();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
